board_draw_scheduler: RTL and testbench
=======================================

Name: board_draw_scheduler

Overview:
Sequences the shared sprite_draw engine to paint the Sokoban board. It walks a ROWS x COLS tile map held in board RAM and issues one sprite draw per tile, waiting for each to complete before issuing the next. Game logic can request a full-board redraw or single-cell redraws after a move; the block arbitrates these onto the single draw engine.

Parameters:
COLS, 10, tiles per row
ROWS, 7, tile rows
ADDR_W, 7, board RAM address width (ROWS*COLS <= 2**ADDR_W)
TILE_SHIFT, 4, log2 tile size in pixels (16x16 tiles)
X_OFF, 0, screen x of tile (0,0); 8-bit
Y_OFF, 0, screen y of tile (0,0); 7-bit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
full_start  in  1  one-cycle pulse: redraw the whole board
cell_req  in  1  single-cell redraw request; held high until cell_ack
cell_row  in  3  row of requested cell; stable while cell_req is high
cell_col  in  4  column of requested cell; stable while cell_req is high
cell_ack  out  1  one-cycle pulse: requested cell drawn (or rejected)
mem_rd_addr  out  ADDR_W  board RAM read address
mem_rd_data  in  3  sprite id; synchronous read, valid 1 cycle after address
draw_start  out  1  one-cycle pulse to sprite_draw
draw_x  out  8  pixel x of tile top-left
draw_y  out  7  pixel y of tile top-left
draw_sprite  out  3  sprite id to draw
draw_done  in  1  one-cycle pulse from sprite_draw: current draw finished
busy  out  1  high whenever not in IDLE
frame_done  out  1  one-cycle pulse after the last tile of a full redraw completes

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; full_pending cleared; row/col counters 0.
- States: IDLE, FETCH, WAIT_RD, ISSUE, BUSY, NEXT.
- IDLE: if full_pending or full_start, clear full_pending, set mode=FULL, row=col=0, go to FETCH. Otherwise, if cell_req is high: out-of-range cell (row>=ROWS or col>=COLS) pulses cell_ack the next cycle and stays in IDLE; otherwise latch row/col, set mode=CELL, go to FETCH. A full redraw has priority over a cell request presented in the same cycle.
- FETCH: drive mem_rd_addr = row*COLS + col, go to WAIT_RD.
- WAIT_RD: capture mem_rd_data into draw_sprite; load draw_x = X_OFF + (col << TILE_SHIFT), truncated to 8 bits, and draw_y = Y_OFF + (row << TILE_SHIFT), truncated to 7 bits; go to ISSUE.
- ISSUE: draw_start=1 for exactly this cycle; go to BUSY.
- BUSY: draw_x, draw_y and draw_sprite are held stable; wait for draw_done, then go to NEXT. draw_done in any other state is ignored.
- NEXT, mode CELL: pulse cell_ack, go to IDLE.
- NEXT, mode FULL: advance col, wrapping to 0 and incrementing row at COLS-1. After (ROWS-1, COLS-1), pulse frame_done and go to IDLE; otherwise go to FETCH.
- Minimum cost per tile: 4 cycles plus draw latency.
- full_start while busy: sets full_pending, which is serviced on the next IDLE. Multiple pulses coalesce into one redraw. A full_start during a full redraw does not restart it.
- cell_req while busy: not acknowledged; it is serviced in IDLE after any pending full redraw.
- Reset mid-draw: returns to IDLE immediately. Any in-flight sprite_draw operation is not tracked.

Decomposition:
- Shared package `sokoban_pkg`:
  - state encoding
  - sprite id width (3)
  - screen width constants (x 8, y 7)
  - TILE_SHIFT default
- Sub-module `tile_coord`: combinational row/col to address and pixel x/y, parameterised by COLS, TILE_SHIFT, X_OFF, Y_OFF. All other logic stays in the top FSM.

Test Plan:
1. Full redraw: reset, then pulse full_start. RAM returns id = addr[2:0]; draw engine model pulses draw_done 5 cycles after each draw_start. Required: 70 draw_start pulses in raster order, tile 11 at x=16, y=16 with sprite 3, exactly one frame_done after the 70th draw_done, busy low afterwards.
2. Single cell: cell_req with row=2, col=3. Required: mem_rd_addr=23, one draw_start with x=48, y=32, then cell_ack one cycle after draw_done. cell_req deasserts and no further draws occur.
3. Rejected cell: cell_req with row=7, col=0. Required: cell_ack within 2 cycles, no draw_start, mem_rd_addr unchanged.
4. Arbitration: full_start and cell_req (1,1) in the same cycle. Required: full redraw of 70 tiles first, then one draw at x=16, y=16, then cell_ack.
5. Coalescing: three full_start pulses during a full redraw. Required: exactly one additional 70-tile redraw follows, giving 2 frame_done pulses total.
6. Reset mid-op: assert reset during BUSY at tile 5. Required: all outputs 0 asynchronously, spurious draw_done ignored afterwards, next full_start begins at addr 0.

Source files
------------

// File: rtl/sokoban_pkg.sv
// Shared types and screen geometry for the Sokoban board display path.
package sokoban_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RD,
        ST_ISSUE,
        ST_BUSY,
        ST_NEXT
    } state_t;

    // What kind of redraw is in progress
    typedef enum logic {
        MODE_FULL,
        MODE_CELL
    } mode_t;

    localparam int SPRITE_W       = 3;
    localparam int SCREEN_X_W     = 8;
    localparam int SCREEN_Y_W     = 7;
    localparam int ROW_W          = 3;
    localparam int COL_W          = 4;
    localparam int TILE_SHIFT_DEF = 4;

endpackage

// File: rtl/tile_coord.sv
// Maps a board cell (row, col) to its board RAM address and the screen
// pixel position of the tile's top-left corner.
module tile_coord
    import sokoban_pkg::*;
#(
    parameter int COLS       = 10,
    parameter int ADDR_W     = 7,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 0
) (
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    output logic [ADDR_W-1:0]     addr,
    output logic [SCREEN_X_W-1:0] px,
    output logic [SCREEN_Y_W-1:0] py
);

    // Row-major address; pixel positions wrap to the screen coordinate widths
    assign addr = ADDR_W'(int'(row) * COLS + int'(col));
    assign px   = SCREEN_X_W'(X_OFF + (int'(col) << TILE_SHIFT));
    assign py   = SCREEN_Y_W'(Y_OFF + (int'(row) << TILE_SHIFT));

endmodule

// File: rtl/board_draw_scheduler.sv
// Walks the board tile map and feeds one sprite draw per tile to the shared
// sprite_draw engine, arbitrating full-board and single-cell redraws.
module board_draw_scheduler
    import sokoban_pkg::*;
#(
    parameter int COLS       = 10,
    parameter int ROWS       = 7,
    parameter int ADDR_W     = 7,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int X_OFF      = 0,
    parameter int Y_OFF      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  full_start,
    input  logic                  cell_req,
    input  logic [ROW_W-1:0]      cell_row,
    input  logic [COL_W-1:0]      cell_col,
    output logic                  cell_ack,
    output logic [ADDR_W-1:0]     mem_rd_addr,
    input  logic [SPRITE_W-1:0]   mem_rd_data,
    output logic                  draw_start,
    output logic [SCREEN_X_W-1:0] draw_x,
    output logic [SCREEN_Y_W-1:0] draw_y,
    output logic [SPRITE_W-1:0]   draw_sprite,
    input  logic                  draw_done,
    output logic                  busy,
    output logic                  frame_done
);

    state_t                  state;
    mode_t                   mode;
    logic                    full_pending;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [ADDR_W-1:0]       tile_addr;
    logic [SCREEN_X_W-1:0]   tile_x;
    logic [SCREEN_Y_W-1:0]   tile_y;
    logic                    last_col;
    logic                    last_tile;
    logic                    cell_in_range;

    tile_coord #(
        .COLS       (COLS),
        .ADDR_W     (ADDR_W),
        .TILE_SHIFT (TILE_SHIFT),
        .X_OFF      (X_OFF),
        .Y_OFF      (Y_OFF)
    ) u_tile_coord (
        .row  (row),
        .col  (col),
        .addr (tile_addr),
        .px   (tile_x),
        .py   (tile_y)
    );

    // The address follows the row/col registers, which are loaded on entry
    // to FETCH, so the RAM sees it for the whole FETCH cycle and its data is
    // ready to capture in WAIT_RD.
    assign mem_rd_addr   = tile_addr;
    assign busy          = (state != ST_IDLE);
    assign last_col      = (col == COL_W'(COLS - 1));
    assign last_tile     = last_col && (row == ROW_W'(ROWS - 1));
    assign cell_in_range = (int'(cell_row) < ROWS) && (int'(cell_col) < COLS);

    // Main sequencer: arbitration, tile walk and registered handshake pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mode         <= MODE_FULL;
            full_pending <= 1'b0;
            row          <= '0;
            col          <= '0;
            draw_start   <= 1'b0;
            draw_x       <= '0;
            draw_y       <= '0;
            draw_sprite  <= '0;
            cell_ack     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            draw_start <= 1'b0;
            cell_ack   <= 1'b0;
            frame_done <= 1'b0;

            if (full_start && state != ST_IDLE) begin
                full_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (full_pending || full_start) begin
                        full_pending <= 1'b0;
                        mode         <= MODE_FULL;
                        row          <= '0;
                        col          <= '0;
                        state        <= ST_FETCH;
                    end else if (cell_req && !cell_ack) begin
                        // Skip the cycle an ack is showing so a held request is not served twice
                        if (cell_in_range) begin
                            row   <= cell_row;
                            col   <= cell_col;
                            mode  <= MODE_CELL;
                            state <= ST_FETCH;
                        end else begin
                            cell_ack <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    draw_sprite <= mem_rd_data;
                    draw_x      <= tile_x;
                    draw_y      <= tile_y;
                    draw_start  <= 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (draw_done) begin
                        state <= ST_NEXT;
                        if (mode == MODE_CELL) begin
                            cell_ack <= 1'b1;
                        end else if (last_tile) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (mode == MODE_CELL || last_tile) begin
                        state <= ST_IDLE;
                    end else begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw_scheduler.sv
// Directed self-checking bench for board_draw_scheduler with a board RAM
// model (id = addr[2:0]) and a sprite_draw model with fixed latency.
module tb_board_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       full_start;
    logic       cell_req;
    logic [2:0] cell_row;
    logic [3:0] cell_col;
    logic       cell_ack;
    logic [6:0] mem_rd_addr;
    logic [2:0] mem_rd_data = 3'd0;
    logic       draw_start;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] draw_sprite;
    logic       draw_done;
    logic       busy;
    logic       frame_done;

    logic       eng_done = 1'b0;
    logic       extra_done;
    int         eng_cnt = 0;
    int         cyc = 0;

    int errors = 0;
    int checks = 0;

    int log_x[$];
    int log_y[$];
    int log_s[$];
    int log_a[$];
    int done_cnt, frame_cnt, frame_done_at, frame_cyc, ack_cnt, ack_cyc, last_done_cyc;

    board_draw_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .full_start  (full_start),
        .cell_req    (cell_req),
        .cell_row    (cell_row),
        .cell_col    (cell_col),
        .cell_ack    (cell_ack),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .draw_start  (draw_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_sprite (draw_sprite),
        .draw_done   (draw_done),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    assign draw_done = eng_done | extra_done;

    // Cycle counter used to time handshakes
    always @(posedge clk) cyc <= cyc + 1;

    // Board RAM: synchronous read, sprite id is the low address bits
    always @(posedge clk) mem_rd_data <= mem_rd_addr[2:0];

    // sprite_draw model: done pulse five cycles after it sees draw_start; not reset
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (draw_start) begin
            eng_cnt <= 5;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_done <= 1'b1;
        end
    end

    // Event logger sampling on the falling edge
    always @(negedge clk) begin
        if (draw_start) begin
            log_x.push_back(int'(draw_x));
            log_y.push_back(int'(draw_y));
            log_s.push_back(int'(draw_sprite));
            log_a.push_back(int'(mem_rd_addr));
        end
        if (draw_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (frame_done) begin
            frame_cnt++;
            frame_done_at = done_cnt;
            frame_cyc = cyc;
        end
        if (cell_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        log_x.delete();
        log_y.delete();
        log_s.delete();
        log_a.delete();
        done_cnt = 0;
        frame_cnt = 0;
        frame_done_at = -1;
        frame_cyc = -1;
        ack_cnt = 0;
        ack_cyc = -1;
        last_done_cyc = -1;
    endtask

    task automatic pulseFull();
        full_start = 1'b1;
        step(1);
        full_start = 1'b0;
    endtask

    task automatic waitIdle(input int limit, input string tag);
        int n = 0;
        while (busy && n < limit) begin
            step(1);
            n++;
        end
        checkOutput(tag, int'(busy), 0);
    endtask

    task automatic waitAck(input int limit, input string tag);
        int n = 0;
        while (!cell_ack && n < limit) begin
            step(1);
            n++;
        end
        checkOutput(tag, int'(cell_ack), 1);
        cell_req = 1'b0;
    endtask

    task automatic waitDraws(input int count, input int limit, input string tag);
        int n = 0;
        while (log_x.size() < count && n < limit) begin
            step(1);
            n++;
        end
        checkOutput(tag, int'(log_x.size() >= count), 1);
    endtask

    // Count of tiles among 70 logged draws starting at base that are out of raster order
    function automatic int rasterBad(input int base);
        int bad = 0;
        if (log_x.size() < base + 70) return 70;
        for (int i = 0; i < 70; i++) begin
            if (log_x[base+i] != (i % 10) * 16 || log_y[base+i] != (i / 10) * 16 ||
                log_s[base+i] != (i % 8) || log_a[base+i] != i)
                bad++;
        end
        return bad;
    endfunction

    task automatic applyStimulus();
        reset = 1'b1;
        full_start = 1'b0;
        cell_req = 1'b0;
        cell_row = 3'd0;
        cell_col = 4'd0;
        extra_done = 1'b0;
        clearLogs();
        step(3);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_addr", int'(mem_rd_addr), 0);
        checkOutput("reset_pulses", int'({draw_start, cell_ack, frame_done}), 0);
        checkOutput("reset_xys", int'({draw_x, draw_y, draw_sprite}), 0);
        reset = 1'b0;
        step(2);

        $display("[TB] full redraw");
        clearLogs();
        pulseFull();
        waitIdle(2000, "t1_idle");
        checkOutput("t1_draws", log_x.size(), 70);
        checkOutput("t1_raster", rasterBad(0), 0);
        checkOutput("t1_tile11_x", (log_x.size() > 11) ? log_x[11] : -1, 16);
        checkOutput("t1_tile11_y", (log_y.size() > 11) ? log_y[11] : -1, 16);
        checkOutput("t1_tile11_s", (log_s.size() > 11) ? log_s[11] : -1, 3);
        checkOutput("t1_frames", frame_cnt, 1);
        checkOutput("t1_frame_after", frame_done_at, 70);

        $display("[TB] single cell");
        clearLogs();
        cell_row = 3'd2;
        cell_col = 4'd3;
        cell_req = 1'b1;
        waitAck(200, "t2_ack");
        step(20);
        checkOutput("t2_draws", log_x.size(), 1);
        checkOutput("t2_addr", (log_a.size() > 0) ? log_a[0] : -1, 23);
        checkOutput("t2_x", (log_x.size() > 0) ? log_x[0] : -1, 48);
        checkOutput("t2_y", (log_y.size() > 0) ? log_y[0] : -1, 32);
        checkOutput("t2_s", (log_s.size() > 0) ? log_s[0] : -1, 7);
        checkOutput("t2_ack_lat", ack_cyc - last_done_cyc, 1);
        checkOutput("t2_ack_cnt", ack_cnt, 1);
        checkOutput("t2_frames", frame_cnt, 0);

        $display("[TB] rejected cells");
        clearLogs();
        cell_row = 3'd7;
        cell_col = 4'd0;
        cell_req = 1'b1;
        waitAck(2, "t3_row_ack");
        step(10);
        checkOutput("t3_row_draws", log_x.size(), 0);
        checkOutput("t3_row_addr", int'(mem_rd_addr), 23);
        checkOutput("t3_row_ack_cnt", ack_cnt, 1);
        checkOutput("t3_row_busy", int'(busy), 0);
        clearLogs();
        cell_row = 3'd0;
        cell_col = 4'd10;
        cell_req = 1'b1;
        waitAck(2, "t3_col_ack");
        step(10);
        checkOutput("t3_col_draws", log_x.size(), 0);
        checkOutput("t3_col_addr", int'(mem_rd_addr), 23);

        $display("[TB] arbitration");
        clearLogs();
        full_start = 1'b1;
        cell_row = 3'd1;
        cell_col = 4'd1;
        cell_req = 1'b1;
        step(1);
        full_start = 1'b0;
        waitAck(3000, "t4_ack");
        step(10);
        checkOutput("t4_draws", log_x.size(), 71);
        checkOutput("t4_raster", rasterBad(0), 0);
        checkOutput("t4_frames", frame_cnt, 1);
        checkOutput("t4_cell_x", (log_x.size() > 70) ? log_x[70] : -1, 16);
        checkOutput("t4_cell_y", (log_y.size() > 70) ? log_y[70] : -1, 16);
        checkOutput("t4_cell_a", (log_a.size() > 70) ? log_a[70] : -1, 11);
        checkOutput("t4_ack_order", int'(ack_cyc > frame_cyc), 1);
        checkOutput("t4_ack_cnt", ack_cnt, 1);

        $display("[TB] coalescing");
        clearLogs();
        pulseFull();
        waitDraws(10, 500, "t5_started");
        for (int k = 0; k < 3; k++) begin
            pulseFull();
            step(30);
        end
        begin
            int n = 0;
            while (frame_cnt < 2 && n < 5000) begin
                step(1);
                n++;
            end
        end
        step(50);
        checkOutput("t5_frames", frame_cnt, 2);
        checkOutput("t5_draws", log_x.size(), 140);
        checkOutput("t5_raster_a", rasterBad(0), 0);
        checkOutput("t5_raster_b", rasterBad(70), 0);
        checkOutput("t5_busy", int'(busy), 0);

        $display("[TB] reset mid-draw");
        clearLogs();
        pulseFull();
        waitDraws(6, 500, "t6_started");
        step(2);
        checkOutput("t6_pre_addr", int'(mem_rd_addr), 5);
        checkOutput("t6_pre_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_async_busy", int'(busy), 0);
        checkOutput("t6_async_addr", int'(mem_rd_addr), 0);
        checkOutput("t6_async_xys", int'({draw_x, draw_y, draw_sprite}), 0);
        checkOutput("t6_async_pulses", int'({draw_start, cell_ack, frame_done}), 0);
        step(2);
        reset = 1'b0;
        clearLogs();
        step(8);
        extra_done = 1'b1;
        step(1);
        extra_done = 1'b0;
        step(5);
        checkOutput("t6_spurious_seen", int'(done_cnt > 0), 1);
        checkOutput("t6_no_draws", log_x.size(), 0);
        checkOutput("t6_idle", int'(busy), 0);
        pulseFull();
        waitDraws(1, 100, "t6_restart");
        checkOutput("t6_first_addr", (log_a.size() > 0) ? log_a[0] : -1, 0);
        checkOutput("t6_first_x", (log_x.size() > 0) ? log_x[0] : -1, 0);
        waitIdle(2000, "t6_idle_end");
        checkOutput("t6_frames", frame_cnt, 1);
        checkOutput("t6_draws", log_x.size(), 70);
    endtask

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
